// File: rtl/pf_lanectrl_pause_gen.sv
// Clock-pause initiator: pauses HS_IO_CLK, strobes delay-line load mid-window, four-phase handshake.
// Optional completed-pause counter on PAUSE_COUNT when PF_LANECTRL_PAUSE_CNT_EN is defined.
module pf_lanectrl_pause_gen #(
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 3,
  parameter int GAP_CYC   = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       UPDATE_REQ,
  output logic       UPDATE_ACK,
  output logic       HS_IO_CLK_PAUSE,
  output logic       DELAY_LINE_LOAD,
  output logic       BUSY
`ifdef PF_LANECTRL_PAUSE_CNT_EN
  ,
  output logic [7:0] PAUSE_COUNT
`endif
);

  // state | meaning
  // IDLE  | waiting for UPDATE_REQ       SETUP | pause high, before load strobe
  // LOAD  | load strobe cycle            HOLD  | pause high, after load strobe
  // ACK   | UPDATE_ACK high, await drop  GAP   | idle spacing before next request
  typedef enum logic [2:0] {IDLE, SETUP, LOAD, HOLD, ACK, GAP} state_t;

  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYC);

  if (SETUP_CYC < 1 || SETUP_CYC > 255) begin : g_bad_setup
    $error("pf_lanectrl_pause_gen: SETUP_CYC out of range 1..255");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > 255) begin : g_bad_hold
    $error("pf_lanectrl_pause_gen: HOLD_CYC out of range 1..255");
  end
  if (GAP_CYC < 0 || GAP_CYC > 255) begin : g_bad_gap
    $error("pf_lanectrl_pause_gen: GAP_CYC out of range 0..255");
  end

  state_t     state;
  logic [7:0] cnt;
  logic       req_dropped;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state           <= IDLE;
      cnt             <= 8'd0;
      req_dropped     <= 1'b0;
      UPDATE_ACK      <= 1'b0;
      HS_IO_CLK_PAUSE <= 1'b0;
      DELAY_LINE_LOAD <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (UPDATE_REQ) begin
            state           <= SETUP;
            HS_IO_CLK_PAUSE <= 1'b1;
            cnt             <= SETUP_LD;
            req_dropped     <= 1'b0;
          end
        end
        SETUP: begin
          if (!UPDATE_REQ) req_dropped <= 1'b1;
          if (cnt == 8'd0) begin
            state           <= LOAD;
            DELAY_LINE_LOAD <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        LOAD: begin
          if (!UPDATE_REQ) req_dropped <= 1'b1;
          DELAY_LINE_LOAD <= 1'b0;
          cnt             <= HOLD_LD;
          state           <= HOLD;
        end
        HOLD: begin
          if (!UPDATE_REQ) req_dropped <= 1'b1;
          if (cnt == 8'd0) begin
            HS_IO_CLK_PAUSE <= 1'b0;
            UPDATE_ACK      <= 1'b1;
            state           <= ACK;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ACK: begin
          // A request dropped during the pause still gets a one-cycle acknowledge.
          if (!UPDATE_REQ || req_dropped) begin
            UPDATE_ACK <= 1'b0;
            cnt        <= GAP_LD;
            state      <= (GAP_CYC == 0) ? IDLE : GAP;
          end
        end
        GAP: begin
          if (cnt <= 8'd1) state <= IDLE;
          else             cnt   <= cnt - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY = (state != IDLE);

`ifdef PF_LANECTRL_PAUSE_CNT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PAUSE_COUNT <= 8'd0;
    end else if (state == HOLD && cnt == 8'd0 && PAUSE_COUNT != 8'hFF) begin
      PAUSE_COUNT <= PAUSE_COUNT + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pf_lanectrl_pause_gen.sv
// Directed bench for pf_lanectrl_pause_gen: default (2,3,4) and minimum (1,1,0) parameter instances.
// Counter checks run only when PF_LANECTRL_PAUSE_CNT_EN is defined.
module tb_pf_lanectrl_pause_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic req_a = 1'b0, ack_a, pause_a, load_a, busy_a;
  logic req_b = 1'b0, ack_b, pause_b, load_b, busy_b;
`ifdef PF_LANECTRL_PAUSE_CNT_EN
  logic [7:0] count_a, count_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pf_lanectrl_pause_gen #(.SETUP_CYC(2), .HOLD_CYC(3), .GAP_CYC(4)) dut_a (
    .CLK(clk), .RESET(rst), .UPDATE_REQ(req_a), .UPDATE_ACK(ack_a),
    .HS_IO_CLK_PAUSE(pause_a), .DELAY_LINE_LOAD(load_a), .BUSY(busy_a)
`ifdef PF_LANECTRL_PAUSE_CNT_EN
    , .PAUSE_COUNT(count_a)
`endif
  );

  pf_lanectrl_pause_gen #(.SETUP_CYC(1), .HOLD_CYC(1), .GAP_CYC(0)) dut_b (
    .CLK(clk), .RESET(rst), .UPDATE_REQ(req_b), .UPDATE_ACK(ack_b),
    .HS_IO_CLK_PAUSE(pause_b), .DELAY_LINE_LOAD(load_b), .BUSY(busy_b)
`ifdef PF_LANECTRL_PAUSE_CNT_EN
    , .PAUSE_COUNT(count_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  // one full handshake on the minimum-parameter instance, bounded wait for ACK
  task automatic hs_b;
    int i;
    req_b = 1'b1;
    i = 0;
    while (!ack_b && i < 20) begin
      step();
      i++;
    end
    if (!ack_b) chk("hs_b_ack_timeout", 32'(ack_b), 32'd1);
    req_b = 1'b0;
    step();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int np, nl, na;
    #1;
    chk("rst_pause", 32'(pause_a), 32'd0);
    chk("rst_load",  32'(load_a),  32'd0);
    chk("rst_ack",   32'(ack_a),   32'd0);
    chk("rst_busy",  32'(busy_a),  32'd0);
    step();
    step();
    rst = 1'b0;
    step();

    // basic handshake, samples taken after edges 0..6
    req_a = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      step();
      chk($sformatf("basic_pause_e%0d", k), 32'(pause_a), 32'(k <= 5));
      chk($sformatf("basic_load_e%0d", k),  32'(load_a),  32'(k == 2));
      chk($sformatf("basic_ack_e%0d", k),   32'(ack_a),   32'(k == 6));
      chk($sformatf("basic_busy_e%0d", k),  32'(busy_a),  32'd1);
    end
    req_a = 1'b0;
    step();
    chk("basic_ack_fall", 32'(ack_a),  32'd0);
    chk("basic_busy_m",   32'(busy_a), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("basic_busy_m%0d", i), 32'(busy_a), 32'(i < 4));
    end

    // back-to-back: re-raise right after ACK falls
    req_a = 1'b1;
    for (int k = 0; k <= 6; k++) step();
    chk("b2b_ack1", 32'(ack_a), 32'd1);
    req_a = 1'b0;
    step();
    chk("b2b_ack1_fall", 32'(ack_a), 32'd0);
    req_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("b2b_gap_pause_m%0d", i), 32'(pause_a), 32'd0);
    end
    step();
    chk("b2b_pause_m5", 32'(pause_a), 32'd1);
    nl = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (load_a) nl++;
    end
    chk("b2b_ack2", 32'(ack_a), 32'd1);
    chk("b2b_loads", 32'(nl), 32'd1);
    req_a = 1'b0;
    step();
    np = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (pause_a) np++;
    end
    chk("b2b_no_extra_pause", 32'(np), 32'd0);
    chk("b2b_idle", 32'(busy_a), 32'd0);

    // early drop: one-cycle request
    req_a = 1'b1;
    step();
    req_a = 1'b0;
    np = 0; nl = 0; na = 0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) step();
      if (pause_a) np++;
      if (load_a)  nl++;
      if (ack_a)   na++;
    end
    chk("drop_pause_width", 32'(np), 32'd6);
    chk("drop_loads",       32'(nl), 32'd1);
    chk("drop_ack_width",   32'(na), 32'd1);
    chk("drop_idle",        32'(busy_a), 32'd0);

    // minimum parameters 1/1/0
    req_b = 1'b1;
    step();
    chk("min_pause_e0", 32'(pause_b), 32'd1);
    chk("min_load_e0",  32'(load_b),  32'd0);
    step();
    chk("min_pause_e1", 32'(pause_b), 32'd1);
    chk("min_load_e1",  32'(load_b),  32'd1);
    step();
    chk("min_pause_e2", 32'(pause_b), 32'd1);
    chk("min_load_e2",  32'(load_b),  32'd0);
    step();
    chk("min_pause_e3", 32'(pause_b), 32'd0);
    chk("min_ack_e3",   32'(ack_b),   32'd1);
    req_b = 1'b0;
    step();
    chk("min_ack_m",  32'(ack_b),  32'd0);
    chk("min_busy_m", 32'(busy_b), 32'd0);
    req_b = 1'b1;
    step();
    chk("min_reaccept_m1", 32'(pause_b), 32'd1);
    hs_b();

`ifdef PF_LANECTRL_PAUSE_CNT_EN
    // hs_b above completed the second handshake already; restart counting from reset
    rst = 1'b1;
    #1;
    chk("cnt_reset0", 32'(count_b), 32'd0);
    step();
    rst = 1'b0;
    step();
    for (int n = 1; n <= 257; n++) begin
      hs_b();
      if (n == 1)   chk("cnt_after_1",   32'(count_b), 32'd1);
      if (n == 255) chk("cnt_after_255", 32'(count_b), 32'd255);
      if (n == 257) chk("cnt_after_257", 32'(count_b), 32'd255);
    end
`endif

    // reset during HOLD
    req_a = 1'b1;
    for (int k = 0; k <= 4; k++) step();
    chk("rstmid_pause_pre", 32'(pause_a), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_pause", 32'(pause_a), 32'd0);
    chk("rstmid_load",  32'(load_a),  32'd0);
    chk("rstmid_ack",   32'(ack_a),   32'd0);
    chk("rstmid_busy",  32'(busy_a),  32'd0);
`ifdef PF_LANECTRL_PAUSE_CNT_EN
    chk("rstmid_count_a", 32'(count_a), 32'd0);
    chk("rstmid_count_b", 32'(count_b), 32'd0);
`endif
    req_a = 1'b0;
    step();
    rst = 1'b0;
    np = 0; nl = 0; na = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (pause_a) np++;
      if (load_a)  nl++;
      if (busy_a)  na++;
    end
    chk("post_rst_pause", 32'(np), 32'd0);
    chk("post_rst_load",  32'(nl), 32'd0);
    chk("post_rst_busy",  32'(na), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pf_lanectrl_pause_gen.md
# pf_lanectrl_pause_gen

Initiator side of the lane-controller clock-pause protocol. Training and calibration logic requests a delay-code update. This block then:
- raises HS_IO_CLK_PAUSE for a fixed, parameterised window;
- fires a single-cycle load strobe to the lane delay lines in the middle of that window;
- completes a four-phase request/acknowledge handshake with the requester.

It sits in the DDR PHY lane block, in the same CLK domain as the pause synchroniser that consumes HS_IO_CLK_PAUSE.

## Interface
Parameters:
- SETUP_CYC, 2: cycles HS_IO_CLK_PAUSE is high before the load strobe (1..255)
- HOLD_CYC, 3: cycles HS_IO_CLK_PAUSE stays high after the load strobe (1..255)
- GAP_CYC, 4: minimum idle cycles after handshake completion before a new request is accepted (0..255)

Ports:
- CLK  in  1  lane control clock; all logic on rising edge
- RESET  in  1  asynchronous, active-high
- UPDATE_REQ  in  1  update request; four-phase, held high until UPDATE_ACK is seen
- UPDATE_ACK  out  1  registered acknowledge
- HS_IO_CLK_PAUSE  out  1  registered pause request to the synchroniser
- DELAY_LINE_LOAD  out  1  registered single-cycle load strobe to lane delay lines
- BUSY  out  1  high in every state except IDLE
- PAUSE_COUNT  out  8  completed-pause counter (present only with PF_LANECTRL_PAUSE_CNT_EN)

## Operation
- Reset value of all outputs is 0. The state machine resets to IDLE and all counters to 0.
- States: IDLE, SETUP, LOAD, HOLD, ACK, GAP. Down-counter cnt is 8 bits wide.
- IDLE: if UPDATE_REQ=1, go to SETUP, set HS_IO_CLK_PAUSE=1 and load cnt=SETUP_CYC-1.
- SETUP: decrement cnt. When cnt=0, go to LOAD and set DELAY_LINE_LOAD=1.
- LOAD: lasts exactly one cycle. Clear DELAY_LINE_LOAD, go to HOLD and load cnt=HOLD_CYC-1.
- HOLD: decrement cnt. When cnt=0, clear HS_IO_CLK_PAUSE, set UPDATE_ACK=1 and go to ACK.
- ACK: wait for UPDATE_REQ=0. On that edge, clear UPDATE_ACK and load cnt=GAP_CYC. Go to GAP, or go straight to IDLE if GAP_CYC=0.
- GAP: decrement cnt. When cnt reaches 1, go to IDLE on the next edge.
- Early request drop: if UPDATE_REQ falls before the ACK state is reached, the pause sequence still completes. UPDATE_ACK pulses for exactly one cycle and the machine then proceeds as if UPDATE_REQ=0 had been seen in ACK.
- UPDATE_REQ is ignored in SETUP, LOAD, HOLD and GAP. Requests are never queued.
- HS_IO_CLK_PAUSE and DELAY_LINE_LOAD are never glitched. Both are driven directly from flops.
- Out-of-range parameter values are illegal. The simulation model issues $error at time 0.

## Timing
- Take edge 0 as the edge that samples UPDATE_REQ=1 in IDLE. From that edge:
  - HS_IO_CLK_PAUSE and BUSY are high after edge 0.
  - DELAY_LINE_LOAD is high in the cycle after edge SETUP_CYC.
  - HS_IO_CLK_PAUSE falls and UPDATE_ACK rises after edge SETUP_CYC+1+HOLD_CYC.
  - Pause width is therefore exactly SETUP_CYC+1+HOLD_CYC cycles. DELAY_LINE_LOAD is always strictly inside the pause window.
- Take edge m as the edge that samples UPDATE_REQ=0 in ACK. From that edge:
  - UPDATE_ACK falls after edge m.
  - BUSY falls after edge m+GAP_CYC.
  - The earliest acceptance of a new request is edge m+GAP_CYC+1.
- Latency from request to acknowledge is SETUP_CYC+HOLD_CYC+2 edges, counting edge 0.
- Asserting RESET mid-sequence clears all outputs immediately (asynchronous). No load strobe is issued after RESET rises, and PAUSE_COUNT is cleared.

## Configuration
- PF_LANECTRL_PAUSE_CNT_EN defined:
  - PAUSE_COUNT is present.
  - It increments by 1 on each HOLD->ACK transition and saturates at 8'hFF. It does not wrap.
- PF_LANECTRL_PAUSE_CNT_EN undefined:
  - The port and the counter are absent.
  - All other behaviour is identical.

## Test plan
- Basic handshake with SETUP=2, HOLD=3, GAP=4:
  - Stimulus: REQ high at edge 0, dropped one cycle after ACK is seen.
  - Required response: PAUSE high after edges 0..5; LOAD high only after edge 2; ACK rises after edge 6; BUSY low 4 cycles after REQ low is sampled.
- Back-to-back requests: REQ re-raised immediately after ACK falls -> second PAUSE rises no earlier than edge m+5. No request is lost, and none is double-served.
- Early drop: REQ high for 1 cycle only -> full 6-cycle PAUSE, exactly one LOAD pulse, and a 1-cycle ACK pulse.
- Reset mid-operation: RESET asserted during HOLD -> PAUSE, LOAD, ACK and BUSY read 0 in the same cycle. After release with REQ=0, the block stays idle.
- Counter (PF_LANECTRL_PAUSE_CNT_EN): 257 complete handshakes -> PAUSE_COUNT reads 1 after the first, 255 after the 255th, and stays at 255 after the 257th. It reads 0 after RESET.
- Minimum parameters SETUP=1, HOLD=1, GAP=0 -> PAUSE is 3 cycles wide with LOAD in the middle cycle. A new request is accepted on the edge after REQ low is sampled.
